pipeline_controller: RTL and testbench
======================================

Name: pipeline_controller

Overview:
- Central control unit for the decode/execute datapath of the three-stage pipeline.
- Decodes the decode-stage and execute-stage instructions into datapath selects, ALU control and forwarding selects.
- Runs a small FSM that stalls the pipeline across variable-latency data-memory accesses and load-use hazards.
- Generates the one-cycle flush after taken branches and jumps.

Parameters:
- XLEN, 32, instruction/data width.
- NOP_INSTR, 32'h0000_0013, value treated as a bubble (addi x0,x0,0); never forwards and never writes.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- instruction  in  32  decode-stage instruction.
- instruction_ppl  in  32  execute-stage instruction, from the decode/exec pipeline register.
- br_taken  in  1  branch comparator result for the decode-stage instruction.
- dmem_ack  in  1  data memory completes the current request this cycle.
- reg_wr  out  1  regfile write enable for the instruction_ppl rd.
- wb_sel  out  2  writeback source: 0 ALU, 1 load data, 2 PC+4.
- A_sel  out  1  1 = rs1 operand, 0 = PC.
- B_sel  out  1  1 = immediate, 0 = rs2.
- forw_a  out  1  forward exec ALU result onto rs1.
- forw_b  out  1  forward exec ALU result onto rs2.
- ALUctrl  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- stall  out  1  hold all pipeline registers and PC.
- flush  out  1  squash the decode-stage instruction and redirect the PC.
- dmem_req  out  1  data memory request valid.
- dmem_we  out  1  request is a store.

Behaviour:
- Reset (rst=0, asynchronous): FSM=RUN, taken_q=0.
  - All outputs are 0 while rst is low, including ALUctrl=0 and wb_sel=0.
- Decode, combinational from instruction:
  - Opcode classes are R, I, Load, Store, Branch, JAL, JALR, LUI, AUIPC.
  - A_sel=0 for AUIPC, JAL and Branch; otherwise 1.
  - B_sel=0 for R only.
  - ALUctrl:
    - R/I types use funct3/funct7[5]; funct7[5] is ignored for I-type except SRAI.
    - Load, Store, JAL, JALR, Branch and AUIPC use ADD.
    - LUI uses PASS_B.
    - Unknown opcodes give ADD.
- Execute-stage classification, from instruction_ppl:
  - wr_ex = R, I, Load, JAL, JALR, LUI or AUIPC, and rd != 0, and instruction_ppl != NOP_INSTR.
  - wb_sel is 1 for Load, 2 for JAL/JALR, 0 otherwise.
- Forwarding:
  - forw_a=1 when wr_ex, the exec instruction is not a Load, rd_ex == rs1, and the decode instruction reads rs1 (not LUI/AUIPC/JAL).
  - forw_b is the same test against rs2, for decode types R, Store and Branch.
  - Both are forced 0 in state REPLAY.
- FSM, three states:
  - RUN:
    - Exec is not a Load/Store: dmem_req=0, stall=0, reg_wr=wr_ex.
    - Exec is a Load/Store: dmem_req=1, dmem_we=Store.
    - If dmem_ack=1, the access completes this cycle with reg_wr=wr_ex.
      - Load whose rd matches a used decode rs1/rs2: stall=1, next=REPLAY.
      - Otherwise: stall=0, stay in RUN.
    - If dmem_ack=0: stall=1, reg_wr=0, next=MEM_WAIT.
  - MEM_WAIT:
    - dmem_req=1 and dmem_we are held stable; stall=1; reg_wr=0.
    - On dmem_ack: completion and load-use test exactly as in RUN.
  - REPLAY:
    - stall=0, dmem_req=0, reg_wr=0, forw_a/forw_b=0; the decode stage reads the freshly written regfile.
    - next=RUN.
- Control flow:
  - taken_q is captured on a clock edge when stall=0 and flush=0 and the decode instruction is JAL, JALR, or a Branch with br_taken=1.
  - taken_q clears on the next edge.
  - flush = taken_q, so it is high for exactly one cycle after the jump/branch leaves decode.
  - A flushed instruction never sets taken_q and never raises a memory request in the following cycle.
- Simultaneous events:
  - stall dominates: taken_q is not captured while stall=1; the branch re-evaluates after the stall.
  - flush and stall are never both 1, because the exec instruction during flush is a jump/branch, never a memory op.
- Reset mid-access: the FSM returns to RUN and dmem_req drops immediately (asynchronously).

Test Plan:
- add x1,x2,x3 then sub x4,x1,x5 -> forw_a=1, forw_b=0, ALUctrl=1 while the sub is in decode.
- Store in exec with dmem_ack low for 3 cycles -> stall=1 and dmem_req=1 for 3 cycles, dmem_we=1, reg_wr=0; released the cycle ack=1.
- lw x5,0(x2) then add x6,x5,x5, ack after 1 cycle -> MEM_WAIT, then the ack cycle gives reg_wr=1, wb_sel=1, stall=1; REPLAY gives stall=0, forw_a=forw_b=0.
- beq with br_taken=1 -> flush=1 for exactly 1 cycle; jal x1 gives wb_sel=2, reg_wr=1, flush pulse.
- Writes to x0 (addi x0,x0,5 followed by a consumer of x0) -> reg_wr=0, forw_a=0.
- rst driven low in MEM_WAIT -> dmem_req, stall and all outputs 0 immediately; after release the FSM is in RUN.

Source files
------------

// File: rtl/pipeline_controller.sv
// Decode/execute control for the three-stage pipeline: datapath selects, ALU op,
// EX->ID forwarding, data-memory stall FSM and the post-branch flush pulse.
module pipeline_controller #(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] instruction,
  input  logic [XLEN-1:0] instruction_ppl,
  input  logic            br_taken,
  input  logic            dmem_ack,
  output logic            reg_wr,
  output logic [1:0]      wb_sel,
  output logic            A_sel,
  output logic            B_sel,
  output logic            forw_a,
  output logic            forw_b,
  output logic [3:0]      ALUctrl,
  output logic            stall,
  output logic            flush,
  output logic            dmem_req,
  output logic            dmem_we
);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_BR = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
                         ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                         ALU_OR = 4'd8, ALU_AND = 4'd9, ALU_PASSB = 4'd10;

  typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, REPLAY = 2'd2} state_t;

  state_t      state_q, state_d;
  logic        taken_q, kill_q;
  logic [6:0]  op_d, op_e;
  logic [4:0]  rs1_d, rs2_d, rd_e;
  logic        d_r, d_i, d_ld, d_st, d_br, d_jal, d_jalr, d_lui, d_auipc;
  logic        e_r, e_i, e_ld, e_st, e_jal, e_jalr, e_lui, e_auipc;
  logic        uses_rs1, uses_rs2, wr_ex, mem_ex, load_use, hit_a, hit_b;
  logic        stall_c, reg_wr_c, req_c, we_c, fwd_en, take;
  logic [3:0]  alu_d;
  logic [1:0]  wb_e;
  logic        unused;

  assign op_d  = instruction[6:0];
  assign rs1_d = instruction[19:15];
  assign rs2_d = instruction[24:20];
  assign op_e  = instruction_ppl[6:0];
  assign rd_e  = instruction_ppl[11:7];
  assign unused = &{1'b0, instruction[XLEN-1], instruction[29:25], instruction[11:7]};

  assign d_r  = op_d == OP_R;   assign d_i    = op_d == OP_I;    assign d_ld    = op_d == OP_LD;
  assign d_st = op_d == OP_ST;  assign d_br   = op_d == OP_BR;   assign d_jal   = op_d == OP_JAL;
  assign d_jalr = op_d == OP_JALR; assign d_lui = op_d == OP_LUI; assign d_auipc = op_d == OP_AUIPC;

  assign e_r  = op_e == OP_R;   assign e_i    = op_e == OP_I;    assign e_ld    = op_e == OP_LD;
  assign e_st = op_e == OP_ST;  assign e_jal  = op_e == OP_JAL;  assign e_jalr  = op_e == OP_JALR;
  assign e_lui = op_e == OP_LUI; assign e_auipc = op_e == OP_AUIPC;

  always_comb begin
    alu_d = ALU_ADD;
    if (d_r || d_i) begin
      case (instruction[14:12])
        3'd0:    alu_d = (d_r && instruction[30]) ? ALU_SUB : ALU_ADD;
        3'd1:    alu_d = ALU_SLL;
        3'd2:    alu_d = ALU_SLT;
        3'd3:    alu_d = ALU_SLTU;
        3'd4:    alu_d = ALU_XOR;
        3'd5:    alu_d = instruction[30] ? ALU_SRA : ALU_SRL;
        3'd6:    alu_d = ALU_OR;
        default: alu_d = ALU_AND;
      endcase
    end else if (d_lui) begin
      alu_d = ALU_PASSB;
    end
  end

  // An instruction squashed by the previous flush may still sit in exec; treat it as a bubble.
  assign wr_ex  = (e_r | e_i | e_ld | e_jal | e_jalr | e_lui | e_auipc) && (rd_e != 5'd0) &&
                  (instruction_ppl != NOP_INSTR) && !kill_q;
  assign mem_ex = (e_ld | e_st) && !kill_q;
  assign wb_e   = e_ld ? 2'd1 : ((e_jal | e_jalr) ? 2'd2 : 2'd0);

  assign uses_rs1 = !(d_lui | d_auipc | d_jal);
  assign uses_rs2 = d_r | d_st | d_br;
  assign hit_a    = wr_ex && uses_rs1 && (rd_e == rs1_d);
  assign hit_b    = wr_ex && uses_rs2 && (rd_e == rs2_d);
  assign load_use = e_ld && (hit_a || hit_b);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:      if (mem_ex) state_d = !dmem_ack ? MEM_WAIT : (load_use ? REPLAY : RUN);
      MEM_WAIT: if (dmem_ack) state_d = load_use ? REPLAY : RUN;
      default:  state_d = RUN;
    endcase
  end

  always_comb begin
    stall_c  = 1'b0;
    reg_wr_c = 1'b0;
    req_c    = 1'b0;
    we_c     = 1'b0;
    fwd_en   = 1'b1;
    case (state_q)
      RUN: begin
        if (mem_ex) begin
          req_c    = 1'b1;
          we_c     = e_st;
          reg_wr_c = dmem_ack & wr_ex;
          stall_c  = dmem_ack ? load_use : 1'b1;
        end else begin
          reg_wr_c = wr_ex;
        end
      end
      MEM_WAIT: begin
        req_c    = 1'b1;
        we_c     = e_st;
        reg_wr_c = dmem_ack & wr_ex;
        stall_c  = dmem_ack ? load_use : 1'b1;
      end
      default: fwd_en = 1'b0;  // REPLAY: decode re-reads the regfile the load just wrote
    endcase
  end

  // Stall wins: a branch held in decode re-evaluates once the stall releases.
  assign take = !stall_c && !taken_q && (d_jal || d_jalr || (d_br && br_taken));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_q <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      taken_q <= take;
      kill_q  <= taken_q && !stall_c;
    end
  end

  assign reg_wr   = rst & reg_wr_c;
  assign wb_sel   = rst ? wb_e : 2'd0;
  assign A_sel    = rst & !(d_auipc | d_jal | d_br);
  assign B_sel    = rst & !d_r;
  assign forw_a   = rst & fwd_en & hit_a & !e_ld;
  assign forw_b   = rst & fwd_en & hit_b & !e_ld;
  assign ALUctrl  = rst ? alu_d : 4'd0;
  assign stall    = rst & stall_c;
  assign flush    = rst & taken_q;
  assign dmem_req = rst & req_c;
  assign dmem_we  = rst & we_c;

endmodule

// File: tb/tb_pipeline_controller.sv
// Directed bench for pipeline_controller: each step queues its expected output
// vector, which is popped and checked mid-cycle on the falling edge.
module tb_pipeline_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instruction, instruction_ppl;
  logic        br_taken, dmem_ack;
  logic        reg_wr, A_sel, B_sel, forw_a, forw_b, stall, flush, dmem_req, dmem_we;
  logic [1:0]  wb_sel;
  logic [3:0]  ALUctrl;
  logic [14:0] obs;
  logic [14:0] exp_q[$];
  string       tag_q[$];
  int          tests = 0, fails = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0]  OPI = 7'b0010011, OPLD = 7'b0000011;

  pipeline_controller dut (
    .clk(clk), .rst(rst), .instruction(instruction), .instruction_ppl(instruction_ppl),
    .br_taken(br_taken), .dmem_ack(dmem_ack), .reg_wr(reg_wr), .wb_sel(wb_sel),
    .A_sel(A_sel), .B_sel(B_sel), .forw_a(forw_a), .forw_b(forw_b), .ALUctrl(ALUctrl),
    .stall(stall), .flush(flush), .dmem_req(dmem_req), .dmem_we(dmem_we)
  );

  always #5 clk = ~clk;
  assign obs = {reg_wr, wb_sel, A_sel, B_sel, forw_a, forw_b, ALUctrl, stall, flush, dmem_req, dmem_we};

  function automatic logic [14:0] mk(input logic rw, input logic [1:0] wb, input logic a, b, fa, fb,
                                     input logic [3:0] alu, input logic st, fl, rq, we);
    return {rw, wb, a, b, fa, fb, alu, st, fl, rq, we};
  endfunction

  function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] itype(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] sw(input logic [4:0] rs2, rs1);
    return {7'd0, rs2, rs1, 3'b010, 5'd0, 7'b0100011};
  endfunction

  function automatic logic [31:0] beq(input logic [4:0] rs1, rs2);
    return {7'd0, rs2, rs1, 3'b000, 5'd0, 7'b1100011};
  endfunction

  task automatic check();
    logic [14:0] e;
    string       t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic cyc(input logic [31:0] d, p, input logic br, ack, input logic [14:0] e, input string tag);
    instruction = d; instruction_ppl = p; br_taken = br; dmem_ack = ack;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired: tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] lw5, base_add;
    logic [14:0] base;
    logic [3:0]  alu_tab [8];
    alu_tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    lw5      = itype(12'd0, 5'd2, 3'b010, 5'd5, OPLD);
    base_add = rtype(7'd0, 5'd3, 5'd2, 3'd0, 5'd1);
    base     = mk(0, 2'd0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 0);

    rst = 1'b0; instruction = NOP; instruction_ppl = NOP; br_taken = 1'b0; dmem_ack = 1'b0;
    @(posedge clk); #1;
    cyc(rtype(7'h20, 5'd5, 5'd1, 3'd0, 5'd4), sw(5'd2, 5'd3), 1, 0, 15'd0, "reset");
    rst = 1'b1;

    // Forwarding and decode selects
    cyc(rtype(7'h20, 5'd5, 5'd1, 3'd0, 5'd4), base_add, 0, 0, mk(1, 0, 1, 0, 1, 0, 4'd1, 0, 0, 0, 0), "fwd_sub");
    cyc(rtype(7'd0, 5'd1, 5'd7, 3'd0, 5'd6), base_add, 0, 0, mk(1, 0, 1, 0, 0, 1, 4'd0, 0, 0, 0, 0), "fwd_b");
    cyc(itype(12'd1, 5'd1, 3'd0, 5'd7, OPI), base_add, 0, 0, mk(1, 0, 1, 1, 1, 0, 4'd0, 0, 0, 0, 0), "itype_no_rs2");
    cyc(itype(12'h403, 5'd9, 3'd5, 5'd8, OPI), NOP, 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd7, 0, 0, 0, 0), "srai");
    cyc(itype(12'h003, 5'd9, 3'd5, 5'd8, OPI), NOP, 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd6, 0, 0, 0, 0), "srli");
    cyc(itype(12'hFFF, 5'd2, 3'd0, 5'd1, OPI), NOP, 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 0), "addi_neg");
    for (int f = 0; f < 8; f++)
      cyc(rtype(7'd0, 5'd3, 5'd2, 3'(f), 5'd1), NOP, 0, 0, mk(0, 0, 1, 0, 0, 0, alu_tab[f], 0, 0, 0, 0), "r_alu");
    cyc(rtype(7'h20, 5'd3, 5'd2, 3'd5, 5'd1), NOP, 0, 0, mk(0, 0, 1, 0, 0, 0, 4'd7, 0, 0, 0, 0), "sra");
    cyc({20'h12345, 5'd3, 7'b0110111}, NOP, 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd10, 0, 0, 0, 0), "lui");
    cyc({20'h12345, 5'd3, 7'b0010111}, NOP, 0, 0, mk(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0), "auipc");
    cyc(32'hFFFF_FFFF, NOP, 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, 0, 0), "unknown_op");

    // Store with three wait cycles
    for (int i = 0; i < 3; i++)
      cyc(NOP, sw(5'd2, 5'd3), 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd0, 1, 0, 1, 1), "st_wait");
    cyc(NOP, sw(5'd2, 5'd3), 0, 1, mk(0, 0, 1, 1, 0, 0, 4'd0, 0, 0, 1, 1), "st_done");
    cyc(NOP, NOP, 0, 0, base, "st_after");

    // Load-use: MEM_WAIT, ack with stall, REPLAY, then forwarding resumes
    cyc(rtype(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), lw5, 0, 0, mk(0, 1, 1, 0, 0, 0, 4'd0, 1, 0, 1, 0), "ld_miss");
    cyc(rtype(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), lw5, 0, 1, mk(1, 1, 1, 0, 0, 0, 4'd0, 1, 0, 1, 0), "ld_ack");
    cyc(rtype(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), lw5, 0, 0, mk(0, 1, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0), "replay");
    cyc(rtype(7'h20, 5'd0, 5'd6, 3'd0, 5'd4), rtype(7'd0, 5'd5, 5'd5, 3'd0, 5'd6), 0, 0,
        mk(1, 0, 1, 0, 1, 0, 4'd1, 0, 0, 0, 0), "post_replay");
    cyc(rtype(7'd0, 5'd7, 5'd7, 3'd0, 5'd6), lw5, 0, 1, mk(1, 1, 1, 0, 0, 0, 4'd0, 0, 0, 1, 0), "ld_hit");
    cyc(NOP, NOP, 0, 0, base, "ld_hit_run");

    // Taken branch: one-cycle flush, squashed store never reaches memory
    cyc(beq(5'd1, 5'd2), NOP, 1, 0, mk(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0), "beq");
    cyc(sw(5'd2, 5'd3), beq(5'd1, 5'd2), 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd0, 0, 1, 0, 0), "beq_flush");
    cyc(NOP, sw(5'd2, 5'd3), 0, 0, base, "flushed_no_req");

    cyc({20'd0, 5'd1, 7'b1101111}, NOP, 0, 0, mk(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 0, 0), "jal");
    cyc(NOP, {20'd0, 5'd1, 7'b1101111}, 0, 0, mk(1, 2'd2, 1, 1, 0, 0, 4'd0, 0, 1, 0, 0), "jal_ex");
    cyc(NOP, NOP, 0, 0, base, "jal_end");

    // Stall dominates a taken branch; it is taken once the stall releases
    cyc(beq(5'd1, 5'd2), sw(5'd2, 5'd3), 1, 0, mk(0, 0, 0, 1, 0, 0, 4'd0, 1, 0, 1, 1), "br_stall");
    cyc(beq(5'd1, 5'd2), sw(5'd2, 5'd3), 1, 1, mk(0, 0, 0, 1, 0, 0, 4'd0, 0, 0, 1, 1), "br_release");
    cyc(NOP, beq(5'd1, 5'd2), 0, 0, mk(0, 0, 1, 1, 0, 0, 4'd0, 0, 1, 0, 0), "br_late_flush");
    cyc(NOP, NOP, 0, 0, base, "br_after");

    // Writes to x0 neither write nor forward
    cyc(rtype(7'd0, 5'd0, 5'd0, 3'd0, 5'd9), itype(12'd5, 5'd0, 3'd0, 5'd0, OPI), 0, 0,
        mk(0, 0, 1, 0, 0, 0, 4'd0, 0, 0, 0, 0), "x0_wr");

    // Reset in MEM_WAIT
    cyc(NOP, lw5, 0, 0, mk(0, 1, 1, 1, 0, 0, 4'd0, 1, 0, 1, 0), "mw_enter");
    rst = 1'b0;
    cyc(NOP, lw5, 0, 0, 15'd0, "rst_mid");
    rst = 1'b1;
    cyc(NOP, NOP, 0, 0, base, "rst_run");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
